// File: rtl/pipe_stage_reg_pkg.sv
// Shared pipeline constants, stage-control bundle and helpers.
// Imported by pipe_stage_reg and pipe_skid_buf.
package pipe_stage_reg_pkg;

    localparam logic [31:0] ZERO_WORD = 32'h0000_0000;

    // addi x0, x0, 0 -- reset/flush payload at IF/ID
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    // width of the {stall, flush} hazard-control bundle
    localparam int PIPE_CTRL_W = 2;

    typedef struct packed {
        logic stall;
        logic flush;
    } pipe_ctrl_t;

    // flush outranks stall: a stage only holds when not killed
    function automatic logic ctrl_hold(input pipe_ctrl_t c);
        return c.stall & ~c.flush;
    endfunction

endpackage

// File: rtl/pipe_skid_buf.sv
// One-entry skid store for pipe_stage_reg.
// Ports: clk, rst (async active-low), clr, wr_en/wr_data, rd_en, valid, data.
module pipe_skid_buf
    import pipe_stage_reg_pkg::*;
#(
    parameter int               WIDTH     = 32,
    parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}}
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic             valid,
    output logic [WIDTH-1:0] data
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid <= 1'b0;
            data  <= RESET_VAL;
        end else if (clr) begin
            valid <= 1'b0;
            data  <= RESET_VAL;
        end else if (wr_en) begin
            valid <= 1'b1;
            data  <= wr_data;
        end else if (rd_en) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/pipe_stage_reg.sv
// Parametrised pipeline stage register with valid/ready and stall/flush.
// Ports: clk, rst (async active-low), in_valid/in_ready/in_data,
//        stall, flush, out_valid/out_ready/out_data.
// Option: define PIPE_STAGE_SKID_EN for a one-entry skid buffer that
//         makes in_ready independent of out_ready.
module pipe_stage_reg
    import pipe_stage_reg_pkg::*;
#(
    parameter int               WIDTH     = 32,
    parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}}
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             stall,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);

    pipe_ctrl_t       ctrl;
    logic             kill;
    logic             hold;
    logic             fire_in;
    logic             fire_out;
    logic             valid_q;
    logic             valid_d;
    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] data_d;

    assign ctrl.stall = stall;
    assign ctrl.flush = flush;
    assign kill       = ctrl.flush;
    assign hold       = ctrl_hold(ctrl);

    // a stalled stage shows a bubble downstream but keeps its beat
    assign out_valid = valid_q & ~stall;
    assign out_data  = data_q;
    assign fire_in   = in_valid & in_ready;
    assign fire_out  = out_valid & out_ready;

`ifdef PIPE_STAGE_SKID_EN

    logic             skid_valid;
    logic             skid_wr;
    logic             skid_rd;
    logic [WIDTH-1:0] skid_data;

    // ready depends only on local state, never on out_ready
    assign in_ready = kill | (~skid_valid & ~stall);

    // beat arrives while the main entry is occupied and not leaving
    assign skid_wr = ~kill & fire_in & valid_q & ~fire_out;
    assign skid_rd = ~kill & fire_out & skid_valid;

    pipe_skid_buf #(
        .WIDTH     (WIDTH),
        .RESET_VAL (RESET_VAL)
    ) u_skid (
        .clk     (clk),
        .rst     (rst),
        .clr     (kill),
        .wr_en   (skid_wr),
        .wr_data (in_data),
        .rd_en   (skid_rd),
        .valid   (skid_valid),
        .data    (skid_data)
    );

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (kill) begin
            valid_d = 1'b0;
            data_d  = RESET_VAL;
        end else if (hold) begin
            valid_d = valid_q;
        end else if (skid_rd) begin
            // in_ready is low while the skid is full, so no new beat
            data_d = skid_data;
        end else if (fire_in && (!valid_q || fire_out)) begin
            valid_d = 1'b1;
            data_d  = in_data;
        end else if (fire_out) begin
            valid_d = 1'b0;
        end
    end

`else

    assign in_ready = kill | (~stall & (~valid_q | out_ready));

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (kill) begin
            valid_d = 1'b0;
            data_d  = RESET_VAL;
        end else if (hold) begin
            valid_d = valid_q;
        end else if (fire_in) begin
            valid_d = 1'b1;
            data_d  = in_data;
        end else if (fire_out) begin
            // payload is left in place; only the valid drops
            valid_d = 1'b0;
        end
    end

`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q <= 1'b0;
            data_q  <= RESET_VAL;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: FIFO-level model checked every cycle,
// plus directed vectors; two instances cover both reset payloads.
module tb_pipe_stage_reg;
    import pipe_stage_reg_pkg::*;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic [31:0] in_data;
    logic        stall;
    logic        flush;
    logic        out_ready;

    logic        a_in_ready, b_in_ready;
    logic        a_out_valid, b_out_valid;
    logic [31:0] a_out_data, b_out_data;

    int n_run  = 0;
    int n_fail = 0;
    bit cmp_en = 0;

`ifdef PIPE_STAGE_SKID_EN
    localparam bit SKID = 1'b1;
`else
    localparam bit SKID = 1'b0;
`endif

    pipe_stage_reg #(.WIDTH(32), .RESET_VAL(32'h0)) dut_a (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(a_in_ready), .in_data(in_data),
        .stall(stall), .flush(flush),
        .out_valid(a_out_valid), .out_ready(out_ready), .out_data(a_out_data)
    );

    pipe_stage_reg #(.WIDTH(32), .RESET_VAL(NOP_INSTR)) dut_b (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(b_in_ready), .in_data(in_data),
        .stall(stall), .flush(flush),
        .out_valid(b_out_valid), .out_ready(out_ready), .out_data(b_out_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- model: bounded FIFO of beats ----------------
    logic [31:0] mq[$];
    logic [31:0] m_last = 32'h0;
    bit          m_last_rst = 1'b1;

    function automatic bit m_in_ready();
        if (flush) return 1'b1;
        if (stall) return 1'b0;
        if (SKID) return mq.size() < 2;
        return (mq.size() == 0) || out_ready;
    endfunction

    function automatic bit m_out_valid();
        return (mq.size() > 0) && !stall;
    endfunction

    function automatic logic [31:0] m_out_data(input logic [31:0] rv);
        if (mq.size() > 0) return mq[0];
        return m_last_rst ? rv : m_last;
    endfunction

    always @(posedge clk or negedge rst) begin
        bit pop;
        bit push;
        if (!rst) begin
            mq.delete();
            m_last_rst = 1'b1;
        end else if (flush) begin
            mq.delete();
            m_last_rst = 1'b1;
        end else if (!stall) begin
            pop  = m_out_valid() && out_ready;
            push = in_valid && m_in_ready();
            if (pop) begin
                m_last     = mq.pop_front();
                m_last_rst = 1'b0;
            end
            if (push) mq.push_back(in_data);
        end
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("cyc_in_ready_a", {31'b0, a_in_ready}, {31'b0, m_in_ready()});
            chk("cyc_in_ready_b", {31'b0, b_in_ready}, {31'b0, m_in_ready()});
            chk("cyc_out_valid_a", {31'b0, a_out_valid}, {31'b0, m_out_valid()});
            chk("cyc_out_valid_b", {31'b0, b_out_valid}, {31'b0, m_out_valid()});
            chk("cyc_out_data_a", a_out_data, m_out_data(32'h0));
            chk("cyc_out_data_b", b_out_data, m_out_data(NOP_INSTR));
        end
    end

    // ---------------- stimulus ----------------
    task automatic set_in(input bit v, input logic [31:0] d, input bit s,
                          input bit f, input bit r);
        in_valid  = v;
        in_data   = d;
        stall     = s;
        flush     = f;
        out_ready = r;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        set_in(0, 32'h0, 0, 0, 0);
        #1;
        rst = 1'b0;
        cmp_en = 1'b1;

        // reset held with a beat offered
        set_in(1, 32'hDEAD_BEEF, 0, 0, 1);
        repeat (3) begin
            cyc();
            chk("rst_out_valid", {31'b0, a_out_valid}, 32'd0);
            chk("rst_out_data", a_out_data, 32'h0);
            chk("rst_out_data_nop", b_out_data, 32'h0000_0013);
        end
        rst = 1'b1;
        cyc();
        chk("rel_out_valid", {31'b0, a_out_valid}, 32'd1);
        chk("rel_out_data", a_out_data, 32'hDEAD_BEEF);

        // streaming, one beat per cycle
        for (int i = 1; i <= 8; i++) begin
            set_in(1, i, 0, 0, 1);
            cyc();
            chk("stream_valid", {31'b0, a_out_valid}, 32'd1);
            chk("stream_data", a_out_data, i);
        end
        set_in(0, 32'h0, 0, 0, 1);
        cyc();
        chk("drain_valid", {31'b0, a_out_valid}, 32'd0);
        chk("drain_hold", a_out_data, 32'h8);

        // stall holds 5 while 6 waits
        set_in(1, 32'h5, 0, 0, 1);
        cyc();
        chk("pre_stall", a_out_data, 32'h5);
        set_in(1, 32'h6, 1, 0, 1);
        #1;
        chk("stall_in_ready", {31'b0, a_in_ready}, 32'd0);
        chk("stall_out_valid", {31'b0, a_out_valid}, 32'd0);
        repeat (2) begin
            cyc();
            chk("stall_hold", a_out_data, 32'h5);
        end
        set_in(1, 32'h6, 0, 0, 1);
        #1;
        chk("unstall_valid", {31'b0, a_out_valid}, 32'd1);
        cyc();
        chk("unstall_load", a_out_data, 32'h6);

        // flush beats stall and discards the offered beat
        set_in(1, 32'h7, 0, 0, 1);
        cyc();
        chk("pre_flush", a_out_data, 32'h7);
        set_in(1, 32'hAA, 1, 1, 0);
        #1;
        chk("flush_in_ready", {31'b0, a_in_ready}, 32'd1);
        cyc();
        chk("flush_valid", {31'b0, a_out_valid}, 32'd0);
        chk("flush_data", a_out_data, 32'h0);
        chk("flush_data_nop", b_out_data, 32'h0000_0013);
        set_in(0, 32'h0, 0, 0, 1);
        cyc();
        chk("post_flush_valid", {31'b0, a_out_valid}, 32'd0);
        chk("post_flush_nop", b_out_data, 32'h0000_0013);

        // backpressure
        set_in(1, 32'h11, 0, 0, 0);
        cyc();
        chk("bp_first", a_out_data, 32'h11);
        set_in(1, 32'h22, 0, 0, 0);
        #1;
        chk("bp_ready_1", {31'b0, a_in_ready}, {31'b0, SKID});
        cyc();
        chk("bp_hold_1", a_out_data, 32'h11);
        set_in(1, 32'h33, 0, 0, 0);
        #1;
        chk("bp_ready_2", {31'b0, a_in_ready}, 32'd0);
        repeat (2) begin
            cyc();
            chk("bp_hold", a_out_data, 32'h11);
            chk("bp_valid", {31'b0, a_out_valid}, 32'd1);
        end
        set_in(0, 32'h0, 0, 0, 1);
        cyc();
        if (SKID) begin
            chk("bp_rel_valid", {31'b0, a_out_valid}, 32'd1);
            chk("bp_rel_order", a_out_data, 32'h22);
            cyc();
        end
        chk("bp_empty", {31'b0, a_out_valid}, 32'd0);

        // asynchronous reset pulse between edges
        set_in(1, 32'h44, 0, 0, 1);
        cyc();
        chk("ar_pre", a_out_data, 32'h44);
        set_in(1, 32'h55, 0, 0, 1);
        #1;
        rst = 1'b0;
        #1;
        chk("ar_valid", {31'b0, a_out_valid}, 32'd0);
        chk("ar_data", a_out_data, 32'h0);
        chk("ar_data_nop", b_out_data, 32'h0000_0013);
        set_in(0, 32'h0, 0, 0, 1);
        #1;
        rst = 1'b1;
        repeat (2) begin
            cyc();
            chk("ar_idle", {31'b0, a_out_valid}, 32'd0);
        end
        set_in(1, 32'h66, 0, 0, 1);
        cyc();
        chk("ar_new_valid", {31'b0, a_out_valid}, 32'd1);
        chk("ar_new_data", a_out_data, 32'h66);
        set_in(0, 32'h0, 0, 0, 1);
        cyc();
        chk("final_empty", {31'b0, a_out_valid}, 32'd0);

        @(negedge clk);
        #1;
        cmp_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
